// File: rtl/spi_pkg.sv
// Shared SPI master/slave definitions: command byte constants, cmdOp encoding,
// FSM state encoding and the command-byte builder.
package spi_pkg;

    // Command bytes understood by the spiifc slave
    localparam logic [7:0] CMD_READ_START  = 8'h01;
    localparam logic [7:0] CMD_READ_MORE   = 8'h02;
    localparam logic [7:0] CMD_WRITE_START = 8'h03;
    localparam logic [7:0] CMD_WRITE_MORE  = 8'h04;
    localparam logic [7:0] CMD_INTERRUPT   = 8'h05;
    localparam logic [7:0] CMD_REG_BASE    = 8'h80;
    localparam logic [7:0] CMD_ID_MASK     = 8'h3F;
    localparam int unsigned CMD_REG_BIT    = 7;
    localparam int unsigned CMD_WE_BIT     = 6;

    localparam int unsigned REG_ID_BITS    = 6;
    localparam int unsigned REG_BYTES      = 4;

    typedef enum logic [1:0] {
        OP_REG_WR    = 2'd0,
        OP_REG_RD    = 2'd1,
        OP_MEM_SEND  = 2'd2,
        OP_MEM_FETCH = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SS_SETUP = 3'd1,
        ST_CMD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_SS_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Build the first byte shifted out for a command
    function automatic logic [7:0] cmd_byte(input op_e op, input logic [REG_ID_BITS-1:0] id);
        logic [7:0] reg_cmd;
        reg_cmd = CMD_REG_BASE | 8'(1 << CMD_REG_BIT) | ({2'b00, id} & CMD_ID_MASK);
        case (op)
            OP_REG_WR:   cmd_byte = reg_cmd | 8'(1 << CMD_WE_BIT);
            OP_REG_RD:   cmd_byte = reg_cmd;
            OP_MEM_SEND: cmd_byte = CMD_READ_START;
            default:     cmd_byte = CMD_WRITE_START;
        endcase
    endfunction

endpackage

// File: rtl/spimaster_sclk.sv
// SPI clock generator: ClkDiv SysClk cycles per half-period, SPI_CLK idles low.
// tick_c marks every half-period boundary; rise_c/fall_c mark the cycles in
// which the clock is about to be driven high/low (only while run is set).
module spimaster_sclk #(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic run,
    output logic sclk,
    output logic tick_c,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CntW-1:0] cnt;

    assign tick_c = en && (cnt == CntW'(ClkDiv - 1));
    assign rise_c = tick_c && run && !sclk;
    assign fall_c = tick_c && run && sclk;

    // Half-period counter and clock toggle; both held cleared while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt <= tick_c ? '0 : cnt + CntW'(1);
            if (tick_c && run) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spimaster.sv
// SPI mode-0 master for the spiifc slave: register write/read and buffered
// memory send/fetch. Optional feature macro: SPIMASTER_DEBUG_EN adds
// debug_out, the last completed byte on the wire.
module spimaster
    import spi_pkg::*;
#(
    parameter int unsigned AddrBits    = 12,
    parameter int unsigned RegAddrBits = 4,
    parameter int unsigned ClkDiv      = 4
) (
    input  logic                   SysClk,
    input  logic                   Reset_n,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [1:0]             cmdOp,
    input  logic [RegAddrBits-1:0] cmdRegAddr,
    input  logic [31:0]            cmdWriteData,
    input  logic [AddrBits-1:0]    cmdLen,
    output logic                   done,
    output logic [31:0]            rdData,
    output logic [AddrBits-1:0]    txMemAddr,
    input  logic [7:0]             txMemData,
    output logic [AddrBits-1:0]    rcMemAddr,
    output logic [7:0]             rcMemData,
    output logic                   rcMemWE,
    output logic                   SPI_CLK,
    output logic                   SPI_MOSI,
    output logic                   SPI_SS,
    input  logic                   SPI_MISO
`ifdef SPIMASTER_DEBUG_EN
    ,
    output logic [7:0]             debug_out
`endif
);

    state_e               state;
    op_e                  op;
    logic [AddrBits-1:0]  rem;
    logic [2:0]           bit_cnt;
    logic [7:0]           tx_sh;
    logic [31:0]          wr_word;
    logic [6:0]           rx_sh;
    logic [31:0]          rd_acc;
    logic                 sclk_en;
    logic                 sclk_run;
    logic                 tick_c;
    logic                 rise_c;
    logic                 fall_c;
    logic [7:0]           next_byte_c;
    logic [7:0]           rx_byte_c;
    logic                 accept_c;
`ifdef SPIMASTER_DEBUG_EN
    logic [7:0]           tx_cur;
`endif

    assign sclk_en   = (state != ST_IDLE);
    assign sclk_run  = (state == ST_SS_SETUP) || (state == ST_CMD) || (state == ST_PAYLOAD);
    assign SPI_MOSI  = tx_sh[7];
    assign rx_byte_c = {rx_sh, SPI_MISO};
    assign accept_c  = cmdValid && cmdReady;

    spimaster_sclk #(
        .ClkDiv (ClkDiv)
    ) u_sclk (
        .clk    (SysClk),
        .rst_n  (Reset_n),
        .en     (sclk_en),
        .run    (sclk_run),
        .sclk   (SPI_CLK),
        .tick_c (tick_c),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Source of the next payload byte; mem-send data was addressed a byte earlier
    always_comb begin
        next_byte_c = 8'h00;
        case (op)
            OP_REG_WR:   next_byte_c = wr_word[31:24];
            OP_MEM_SEND: next_byte_c = txMemData;
            default:     next_byte_c = 8'h00;
        endcase
    end

    // Transaction FSM with all SPI, handshake and buffer-port outputs registered
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            op        <= OP_REG_WR;
            rem       <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            wr_word   <= '0;
            rx_sh     <= '0;
            rd_acc    <= '0;
            cmdReady  <= 1'b1;
            done      <= 1'b0;
            rdData    <= '0;
            txMemAddr <= '0;
            rcMemAddr <= '0;
            rcMemData <= '0;
            rcMemWE   <= 1'b0;
            SPI_SS    <= 1'b1;
        end else begin
            done    <= 1'b0;
            rcMemWE <= 1'b0;
            if (rcMemWE) begin
                rcMemAddr <= rcMemAddr + AddrBits'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        state     <= ST_SS_SETUP;
                        op        <= op_e'(cmdOp);
                        rem       <= (cmdOp[1]) ? cmdLen : AddrBits'(REG_BYTES);
                        wr_word   <= cmdWriteData;
                        bit_cnt   <= '0;
                        tx_sh     <= cmd_byte(op_e'(cmdOp), REG_ID_BITS'(cmdRegAddr));
                        txMemAddr <= '0;
                        rcMemAddr <= '0;
                        cmdReady  <= 1'b0;
                        SPI_SS    <= 1'b0;
                    end
                end

                ST_SS_SETUP, ST_CMD, ST_PAYLOAD: begin
                    // Sample MISO as SPI_CLK goes high
                    if (rise_c) begin
                        rx_sh  <= rx_byte_c[6:0];
                        rd_acc <= {rd_acc[30:0], SPI_MISO};
                        if (state == ST_SS_SETUP) begin
                            state <= ST_CMD;
                        end
                        if ((state == ST_PAYLOAD) && (op == OP_MEM_FETCH) && (bit_cnt == 3'd7)) begin
                            rcMemWE   <= 1'b1;
                            rcMemData <= rx_byte_c;
                        end
                    end
                    // Shift MOSI as SPI_CLK goes low; byte boundaries chain with no gap
                    if (fall_c) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rem != '0) begin
                                state <= ST_PAYLOAD;
                                rem   <= rem - AddrBits'(1);
                                tx_sh <= next_byte_c;
                                if (op == OP_REG_WR) begin
                                    wr_word <= {wr_word[23:0], 8'h00};
                                end
                                if (op == OP_MEM_SEND) begin
                                    txMemAddr <= txMemAddr + AddrBits'(1);
                                end
                            end else begin
                                state  <= ST_SS_HOLD;
                                tx_sh  <= '0;
                                SPI_SS <= 1'b1;
                            end
                        end else begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end

                ST_SS_HOLD: begin
                    if (tick_c) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (op == OP_REG_RD) begin
                            rdData <= rd_acc;
                        end
                    end
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    cmdReady <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    cmdReady <= 1'b1;
                    SPI_SS   <= 1'b1;
                    tx_sh    <= '0;
                end
            endcase
        end
    end

`ifdef SPIMASTER_DEBUG_EN
    // Track the byte currently on MOSI and publish each byte as it completes
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_cur    <= '0;
            debug_out <= '0;
        end else begin
            if ((state == ST_IDLE) && accept_c) begin
                tx_cur <= cmd_byte(op_e'(cmdOp), REG_ID_BITS'(cmdRegAddr));
            end else if (fall_c && (bit_cnt == 3'd7) && (rem != '0)) begin
                tx_cur <= next_byte_c;
            end
            if (rise_c && (bit_cnt == 3'd7)) begin
                if ((state == ST_PAYLOAD) && ((op == OP_MEM_FETCH) || (op == OP_REG_RD))) begin
                    debug_out <= rx_byte_c;
                end else begin
                    debug_out <= tx_cur;
                end
            end
        end
    end
`endif

endmodule
